// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions used by the ALU, the decoder and the
//                ALU built-in self-test engine. Holds the ALU operation
//                encoding, the operation count, the LFSR/MISR polynomials, the
//                BIST state encoding and the MISR compaction step.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // RV32I ALU operation select
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    localparam int          ALU_NUM_OPS = 10;
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY   = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    // One MISR step: shift left with polynomial feedback, then fold in the
    // ALU result and the zero flag (zero flag lands on bit 0).
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] data,
                                              input logic        zero);
        return {sig[30:0], 1'b0}
             ^ (sig[31] ? MISR_POLY : 32'h0)
             ^ data
             ^ {31'b0, zero};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : bist_lfsr32
//  Description : 32-bit right-shifting Galois LFSR used as a BIST operand
//                generator. load has priority over step.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset (value clears to 0)
//                load  - load seed into the register
//                step  - advance the LFSR by one state
//                seed  - value loaded on load
//                value - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr32
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 32'h0;
        end else if (load) begin
            r_value <= seed;
        end else if (step) begin
            r_value <= (r_value >> 1) ^ (r_value[0] ? LFSR_POLY : 32'h0);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bist
//  Description : ALU built-in self-test engine. Sweeps every ALU operation
//                across NUM_PATTERNS LFSR-generated operand pairs, compacts
//                result and zero flag into a 32-bit MISR and compares the
//                final signature with GOLDEN_SIG.
//  Ports       : clk, rst_n            - clock / async active-low reset
//                start, abort          - run request / cancel
//                busy, done, pass      - status (pass valid while done)
//                signature             - current MISR value
//                operand_a/b, alu_control - drive side of the ALU bundle
//                alu_result, alu_zero_flag - ALU response
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bist
    import alu_pkg::*;
#(
    parameter int          NUM_PATTERNS = 64,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero_flag
);

    localparam logic [15:0] c_LAST_PAT = 16'(NUM_PATTERNS - 1);
    localparam logic [3:0]  c_LAST_OP  = 4'(ALU_NUM_OPS - 1);

    bist_state_e r_state;
    bist_state_e w_next_state;

    logic [31:0] w_lfsr_a;
    logic [31:0] w_lfsr_b;
    logic [31:0] r_sig;
    logic [31:0] w_sig_next;
    logic [3:0]  r_op_cnt;
    logic [15:0] r_pat_cnt;
    logic        r_pass;

    logic w_run;
    logic w_launch;
    logic w_last_op;
    logic w_last_pat;
    logic w_step;

    assign w_run      = (r_state == ST_RUN);
    assign w_launch   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_last_op  = (r_op_cnt == c_LAST_OP);
    assign w_last_pat = (r_pat_cnt == c_LAST_PAT);
    // Operands advance once the last operation of a pattern has been sampled.
    assign w_step     = w_run && !abort && w_last_op;
    assign w_sig_next = misr_next(r_sig, alu_result, alu_zero_flag);

    bist_lfsr32 u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_launch),
        .step  (w_step),
        .seed  (LFSR_SEED),
        .value (w_lfsr_a)
    );

    bist_lfsr32 u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_launch),
        .step  (w_step),
        .seed  (~LFSR_SEED),
        .value (w_lfsr_b)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                        w_next_state = ST_IDLE;
                else if (w_last_op && w_last_pat) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // MISR, counters and verdict. An aborted cycle does not compact, so the
    // partial signature stays visible after returning to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig     <= 32'h0;
            r_op_cnt  <= 4'd0;
            r_pat_cnt <= 16'd0;
            r_pass    <= 1'b0;
        end else if (w_launch) begin
            r_sig     <= 32'h0;
            r_op_cnt  <= 4'd0;
            r_pat_cnt <= 16'd0;
            r_pass    <= 1'b0;
        end else if (w_run && abort) begin
            r_pass    <= 1'b0;
        end else if (w_run) begin
            r_sig <= w_sig_next;
            if (w_last_op) begin
                r_op_cnt <= 4'd0;
                if (w_last_pat) begin
                    r_pass <= (w_sig_next == GOLDEN_SIG);
                end else begin
                    r_pat_cnt <= r_pat_cnt + 16'd1;
                end
            end else begin
                r_op_cnt <= r_op_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the ALU bundle is parked at ADD with zero operands outside
    // RUN so the handover mux to the normal drivers sees a quiet bus.
    // ------------------------------------------------------------------
    assign busy        = w_run;
    assign done        = (r_state == ST_DONE);
    assign pass        = r_pass;
    assign signature   = r_sig;
    assign operand_a   = w_run ? w_lfsr_a : 32'h0;
    assign operand_b   = w_run ? w_lfsr_b : 32'h0;
    assign alu_control = w_run ? r_op_cnt : ALU_ADD;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_bist
//  Description : Self-checking bench for alu_bist. A single-pattern instance
//                is driven by a stub ALU; a default instance is driven by a
//                behavioural RV32I ALU with an optional bit-7 stuck-at-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bist;

    localparam logic [31:0] c_SEED      = 32'hACE1_2468;
    localparam logic [31:0] c_LPOLY     = 32'h8020_0003;
    localparam logic [31:0] c_MPOLY     = 32'h04C1_1DB7;
    localparam int          c_FULL_PATS = 64;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << b[4:0];
            3: return {31'b0, $signed(a) < $signed(b)};
            4: return {31'b0, a < b};
            5: return a ^ b;
            6: return a >> b[4:0];
            7: return $signed(a) >>> b[4:0];
            8: return a | b;
            9: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? c_LPOLY : 32'h0);
    endfunction

    function automatic logic [31:0] misr_fold(input logic [31:0] s, input logic [31:0] r,
                                              input logic z);
        return {s[30:0], 1'b0} ^ (s[31] ? c_MPOLY : 32'h0) ^ r ^ {31'b0, z};
    endfunction

    // Signature of a whole run: every pattern, every op, in encoding order.
    function automatic logic [31:0] model_sig(input int npat, input logic stuck_b7);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [31:0] r;
        logic        z;
        a = c_SEED;
        b = ~c_SEED;
        s = 32'h0;
        for (int p = 0; p < npat; p++) begin
            for (int op = 0; op < 10; op++) begin
                r = ref_alu(op, a, b);
                z = (r == 32'h0);
                if (stuck_b7) r = r | 32'h80;
                s = misr_fold(s, r, z);
            end
            a = lfsr_next(a);
            b = lfsr_next(b);
        end
        return s;
    endfunction

    localparam logic [31:0] c_GOLD = model_sig(c_FULL_PATS, 1'b0);

    // ---------------- signals ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_start, s_abort, s_busy, s_done, s_pass, s_zero;
    logic [31:0] s_sig, s_a, s_b, s_result;
    logic [3:0]  s_ctrl;
    logic        f_start, f_abort, f_busy, f_done, f_pass, f_zero;
    logic [31:0] f_sig, f_a, f_b, f_result, f_true;
    logic [3:0]  f_ctrl;
    logic        stuck;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_bist #(.NUM_PATTERNS(1), .LFSR_SEED(c_SEED), .GOLDEN_SIG(32'h0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig),
        .operand_a(s_a), .operand_b(s_b), .alu_control(s_ctrl),
        .alu_result(s_result), .alu_zero_flag(s_zero)
    );

    alu_bist #(.NUM_PATTERNS(c_FULL_PATS), .LFSR_SEED(c_SEED), .GOLDEN_SIG(c_GOLD)) u_full (
        .clk(clk), .rst_n(rst_n), .start(f_start), .abort(f_abort),
        .busy(f_busy), .done(f_done), .pass(f_pass), .signature(f_sig),
        .operand_a(f_a), .operand_b(f_b), .alu_control(f_ctrl),
        .alu_result(f_result), .alu_zero_flag(f_zero)
    );

    // Behavioural ALU; the stuck-at fault sits on the result output only.
    always_comb begin
        f_true   = ref_alu(int'(f_ctrl), f_a, f_b);
        f_zero   = (f_true == 32'h0);
        f_result = f_true | (stuck ? 32'h80 : 32'h0);
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: stub returns 0; mode 1: 1 in first RUN cycle only; mode 2: random
    task automatic run_small(input int mode, output logic [31:0] exp_sig, output int cycles);
        logic [31:0] s;
        logic [31:0] r;
        logic        z;
        s = 32'h0;
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        check_val("small_restart_busy", 32'(s_busy), 32'd1);
        check_val("small_restart_done", 32'(s_done), 32'd0);
        check_val("small_restart_pass", 32'(s_pass), 32'd0);
        cycles = 0;
        while (s_busy && cycles < 100) begin
            check_val("small_ctrl", 32'(s_ctrl), 32'(cycles));
            check_val("small_opa", s_a, c_SEED);
            check_val("small_opb", s_b, ~c_SEED);
            r = 32'h0;
            z = 1'b0;
            if (mode == 1 && cycles == 0) r = 32'h1;
            if (mode == 2) begin
                r = $urandom;
                z = 1'($urandom_range(0, 1));
            end
            s_result = r;
            s_zero   = z;
            s = misr_fold(s, r, z);
            cycles++;
            @(negedge clk);
        end
        s_result = 32'h0;
        s_zero   = 1'b0;
        exp_sig  = s;
    endtask

    // Full run with random start pulses while busy (must be ignored).
    task automatic run_full(output int cycles);
        @(negedge clk) f_start = 1'b1;
        @(negedge clk) f_start = 1'b0;
        cycles = 0;
        while (f_busy && cycles < 2000) begin
            cycles++;
            f_start = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        f_start = 1'b0;
    endtask

    task automatic check_full_idle(input string tag);
        check_val({tag, "_busy"}, 32'(f_busy), 32'd0);
        check_val({tag, "_done"}, 32'(f_done), 32'd0);
        check_val({tag, "_pass"}, 32'(f_pass), 32'd0);
        check_val({tag, "_opa"},  f_a, 32'h0);
        check_val({tag, "_opb"},  f_b, 32'h0);
        check_val({tag, "_ctrl"}, 32'(f_ctrl), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        logic [31:0] hold;
        int          n;
        rst_n = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_result = 32'h0; s_zero = 1'b0;
        f_start = 1'b0; f_abort = 1'b0; stuck = 1'b0;
        #12;
        check_val("rst_busy", 32'(s_busy), 32'd0);
        check_val("rst_done", 32'(s_done), 32'd0);
        check_val("rst_pass", 32'(s_pass), 32'd0);
        check_val("rst_sig",  s_sig, 32'h0);
        check_val("rst_opa",  s_a, 32'h0);
        check_val("rst_opb",  s_b, 32'h0);
        check_val("rst_ctrl", 32'(s_ctrl), 32'd0);
        check_full_idle("rst_full");
        @(negedge clk) rst_n = 1'b1;

        // single pattern, all-zero ALU
        run_small(0, e, n);
        check_val("zero_cycles", 32'(n), 32'd10);
        check_val("zero_done",   32'(s_done), 32'd1);
        check_val("zero_sig",    s_sig, 32'h0);
        check_val("zero_pass",   32'(s_pass), 32'd1);

        // single pattern, 1 in first cycle; restart from DONE
        run_small(1, e, n);
        check_val("one_cycles", 32'(n), 32'd10);
        check_val("one_sig",    s_sig, 32'h0000_0200);
        check_val("one_pass",   32'(s_pass), 32'd0);
        check_val("one_done",   32'(s_done), 32'd1);

        // single pattern, random responses
        for (int k = 0; k < 3; k++) begin
            run_small(2, e, n);
            check_val("rnd_cycles", 32'(n), 32'd10);
            check_val("rnd_sig",    s_sig, e);
            check_val("rnd_pass",   32'(s_pass), 32'(e == 32'h0));
        end

        // full run with the real ALU, golden equals the model signature
        run_full(n);
        check_val("full_cycles", 32'(n), 32'd640);
        check_val("full_done",   32'(f_done), 32'd1);
        check_val("full_sig",    f_sig, model_sig(c_FULL_PATS, 1'b0));
        check_val("full_pass",   32'(f_pass), 32'd1);

        // stuck-at-1 on result bit 7
        stuck = 1'b1;
        run_full(n);
        check_val("stuck_cycles", 32'(n), 32'd640);
        check_val("stuck_sig",    f_sig, model_sig(c_FULL_PATS, 1'b1));
        check_val("stuck_pass",   32'(f_pass), 32'd0);
        stuck = 1'b0;

        // abort after 5 RUN cycles, with start raised too (abort wins)
        @(negedge clk) f_start = 1'b1;
        @(negedge clk) f_start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("pre_abort_busy", 32'(f_busy), 32'd1);
        f_abort = 1'b1;
        f_start = 1'b1;
        @(negedge clk);
        f_abort = 1'b0;
        f_start = 1'b0;
        check_full_idle("abort");
        hold = f_sig;
        repeat (2) @(negedge clk);
        check_val("abort_sig_hold", f_sig, hold);
        check_val("abort_stays_idle", 32'(f_busy), 32'd0);

        run_full(n);
        check_val("rerun_cycles", 32'(n), 32'd640);
        check_val("rerun_sig",    f_sig, model_sig(c_FULL_PATS, 1'b0));
        check_val("rerun_pass",   32'(f_pass), 32'd1);

        // asynchronous reset in the middle of a run
        @(negedge clk) f_start = 1'b1;
        @(negedge clk) f_start = 1'b0;
        repeat ($urandom_range(3, 40)) @(negedge clk);
        check_val("pre_rst_busy", 32'(f_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_full_idle("midrst");
        check_val("midrst_sig", f_sig, 32'h0);
        check_val("midrst_small_done", 32'(s_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test engine that sits on the driving side of the ALU port bundle: operand_a, operand_b and alu_control out; alu_result and alu_zero_flag in.
- On start, it sweeps every RV32I ALU operation across LFSR-generated operand pairs.
- Each result and zero flag is compacted into a 32-bit MISR signature, which is compared against a golden value.
- Used for power-on and test-mode checking of the ALU datapath, with a muxed handover to the decode/execute drivers.

Parameters:
- NUM_PATTERNS, 64: operand pairs applied. Each pair is exercised with all ALU ops. Range 1..65535.
- LFSR_SEED, 32'hACE1_2468: seed for the operand_a LFSR. The operand_b LFSR seed is ~LFSR_SEED. The value must not be 32'h0 or 32'hFFFF_FFFF.
- GOLDEN_SIG, 32'h0000_0000: expected final MISR value.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- abort  in  1  synchronous cancel; honoured only in RUN
- busy  out  1  high while in RUN
- done  out  1  high while in DONE (level, not pulse)
- pass  out  1  valid while done=1: signature matched GOLDEN_SIG
- signature  out  32  current MISR value
- operand_a  out  32  ALU operand A
- operand_b  out  32  ALU operand B
- alu_control  out  4  ALU operation select (alu_pkg encoding)
- alu_result  in  32  ALU result, combinational from current operands
- alu_zero_flag  in  1  ALU zero flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE
  - lfsr_a, lfsr_b, sig, op_cnt, pat_cnt = 0
  - busy=0, done=0, pass=0, signature=0, operand_a=0, operand_b=0, alu_control=ALU_ADD(4'd0)
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - load lfsr_a=LFSR_SEED, lfsr_b=~LFSR_SEED
  - sig=0, op_cnt=0, pat_cnt=0, pass=0
  - next state RUN
- Outside RUN:
  - operand_a, operand_b forced to 0
  - alu_control forced to ALU_ADD
- In RUN:
  - operand_a=lfsr_a, operand_b=lfsr_b, alu_control=op_cnt.
  - The ALU is combinational, so the result is sampled on the same clock edge that ends the cycle.
- Each RUN edge, MISR update:
  - sig <= {sig[30:0],1'b0} ^ (sig[31] ? MISR_POLY : 0) ^ alu_result ^ {31'b0, alu_zero_flag}
- Each RUN edge, op_cnt/pat_cnt update:
  - If op_cnt < ALU_NUM_OPS-1: op_cnt++.
  - Otherwise: op_cnt=0, both LFSRs step once, and pat_cnt advances as follows:
    - If pat_cnt == NUM_PATTERNS-1: go to DONE.
    - Otherwise: pat_cnt++.
- LFSR step (Galois, right shift): l <= (l >> 1) ^ (l[0] ? LFSR_POLY : 0).
- Run length: RUN lasts exactly NUM_PATTERNS*ALU_NUM_OPS cycles. With defaults that is 640.
- Op order per pattern: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- On entry to DONE:
  - pass registered as (final sig == GOLDEN_SIG)
  - signature holds the final value
  - done=1 until the next start or reset
- abort in RUN:
  - next state IDLE
  - busy=0, done=0, pass=0
  - signature holds its partial value
- start while in RUN is ignored.
- start and abort together in RUN: abort wins.
- Counter widths: pat_cnt is 16 bits, op_cnt is 4 bits. Neither wraps; the terminal compare ends the run.
- Reset asserted mid-RUN: immediate return to the reset values. No partial signature is retained.

Decomposition:
- alu_pkg (shared with ALU and decoder):
  - alu_ctrl_e enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - ALU_NUM_OPS=10
  - LFSR_POLY=32'h8020_0003
  - MISR_POLY=32'h04C1_1DB7
- Sub-module bist_lfsr32 (load, step, seed, value), instantiated twice. MISR and FSM stay inline.

Test Plan:
- NUM_PATTERNS=1, stub ALU returning 0/zero=0, start pulse:
  - busy high for exactly 10 cycles
  - alu_control steps 0..9
  - operand_a=32'hACE1_2468, operand_b=32'h531E_DB97 throughout
  - then done=1, signature=0, pass=1 (GOLDEN_SIG=0)
- NUM_PATTERNS=1, stub returns 32'h1 in the first RUN cycle only, else 0 -> signature=32'h0000_0200, pass=0.
- Defaults with the real ALU and a bench reference model:
  - signature equals the model's value after 640 RUN cycles
  - rerun with GOLDEN_SIG set to that value -> pass=1
  - force alu_result bit 7 stuck-at-1 -> pass=0
- Abort after 5 RUN cycles -> IDLE next cycle, busy=0, done=0, operands=0, alu_control=0.
  - A new start -> full 640-cycle run and the same signature as an unaborted run.
- Reset asserted mid-RUN -> all outputs 0 asynchronously.
  - start during RUN has no effect on cycle count.
  - start in DONE restarts the run, clearing done and pass on the next cycle.
